// File: rtl/operand_fetch_pkg.sv
// Shared definitions for the operand-fetch stage.
// Holds the default widths, the ALU opcode constants and the packed ALU control word.
package operand_fetch_pkg;

    localparam int unsigned DATA_W_DEF      = 16;
    localparam int unsigned NREGS_DEF       = 8;
    localparam int unsigned STALL_CNT_W_DEF = 16;
    localparam int unsigned OP_W            = 4;

    // ALU opcodes
    localparam logic [OP_W-1:0] OP_ADD  = 4'h0;
    localparam logic [OP_W-1:0] OP_SUB  = 4'h1;
    localparam logic [OP_W-1:0] OP_AND  = 4'h2;
    localparam logic [OP_W-1:0] OP_OR   = 4'h3;
    localparam logic [OP_W-1:0] OP_XOR  = 4'h4;
    localparam logic [OP_W-1:0] OP_SHL  = 4'h5;
    localparam logic [OP_W-1:0] OP_SHR  = 4'h6;
    localparam logic [OP_W-1:0] OP_PASS = 4'hF;

    // ALU control word, MSB first: {passthrough, invA, invB, sign, Cin}
    typedef struct packed {
        logic passthrough;
        logic inv_a;
        logic inv_b;
        logic sign;
        logic cin;
    } alu_ctrl_t;

endpackage

// File: rtl/operand_fetch_if.sv
// Decode-side and execute-side bus of the operand-fetch stage.
// slave  : used by operand_fetch (consumes decode/hazard inputs, drives ALU outputs)
// master : used by the surrounding pipeline / testbench
interface operand_fetch_if #(
    parameter int unsigned DATA_W      = operand_fetch_pkg::DATA_W_DEF,
    parameter int unsigned NREGS       = operand_fetch_pkg::NREGS_DEF,
    parameter int unsigned STALL_CNT_W = operand_fetch_pkg::STALL_CNT_W_DEF
);
    localparam int unsigned AW = $clog2(NREGS);

    // decode side
    logic                                  in_valid;
    logic                                  in_ready;
    logic [AW-1:0]                         src1_addr;
    logic [AW-1:0]                         src2_addr;
    logic [DATA_W-1:0]                     imm;
    logic                                  use_imm;
    logic [operand_fetch_pkg::OP_W-1:0]    op_in;
    operand_fetch_pkg::alu_ctrl_t          ctrl_in;
    logic [AW-1:0]                         dst_addr_in;
    logic                                  dst_we_in;
    // writeback and downstream producers
    logic                                  wb_we;
    logic [AW-1:0]                         wb_addr;
    logic [DATA_W-1:0]                     wb_data;
    logic                                  ex_vld;
    logic [AW-1:0]                         ex_addr;
    logic [DATA_W-1:0]                     ex_data;
    logic                                  mem_vld;
    logic [AW-1:0]                         mem_addr;
    logic [DATA_W-1:0]                     mem_data;
    logic                                  flush;
    // execute side
    logic                                  out_valid;
    logic                                  out_ready;
    logic [DATA_W-1:0]                     A;
    logic [DATA_W-1:0]                     B;
    logic [operand_fetch_pkg::OP_W-1:0]    Op;
    logic                                  passthrough;
    logic                                  invA;
    logic                                  invB;
    logic                                  sign;
    logic                                  Cin;
    logic [AW-1:0]                         dst_addr_out;
    logic                                  dst_we_out;
    logic [STALL_CNT_W-1:0]                stall_cnt;

    modport slave (
        input  in_valid, src1_addr, src2_addr, imm, use_imm, op_in, ctrl_in,
               dst_addr_in, dst_we_in, wb_we, wb_addr, wb_data,
               ex_vld, ex_addr, ex_data, mem_vld, mem_addr, mem_data,
               flush, out_ready,
        output in_ready, out_valid, A, B, Op, passthrough, invA, invB, sign, Cin,
               dst_addr_out, dst_we_out, stall_cnt
    );

    modport master (
        output in_valid, src1_addr, src2_addr, imm, use_imm, op_in, ctrl_in,
               dst_addr_in, dst_we_in, wb_we, wb_addr, wb_data,
               ex_vld, ex_addr, ex_data, mem_vld, mem_addr, mem_data,
               flush, out_ready,
        input  in_ready, out_valid, A, B, Op, passthrough, invA, invB, sign, Cin,
               dst_addr_out, dst_we_out, stall_cnt
    );

endinterface

// File: rtl/operand_fetch_reg_file.sv
// Architectural register file: NREGS x DATA_W, two combinational read ports,
// one write port, asynchronous active-high clear.
// A read of the address being written this cycle returns the write data (WB bypass).
// Ports: clk, rst, rd1_addr/rd1_data, rd2_addr/rd2_data, we/wr_addr/wr_data.
module operand_fetch_reg_file #(
    parameter int unsigned DATA_W = operand_fetch_pkg::DATA_W_DEF,
    parameter int unsigned NREGS  = operand_fetch_pkg::NREGS_DEF,
    localparam int unsigned AW    = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [AW-1:0]     rd1_addr,
    output logic [DATA_W-1:0] rd1_data,
    input  logic [AW-1:0]     rd2_addr,
    output logic [DATA_W-1:0] rd2_data,
    input  logic              we,
    input  logic [AW-1:0]     wr_addr,
    input  logic [DATA_W-1:0] wr_data
);

    logic [DATA_W-1:0] regs [NREGS];

    // storage
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(NREGS); i++) begin
                regs[i] <= '0;
            end
        end else if (we) begin
            regs[wr_addr] <= wr_data;
        end
    end

    // read ports with same-cycle writeback bypass
    assign rd1_data = (we && (wr_addr == rd1_addr)) ? wr_data : regs[rd1_addr];
    assign rd2_data = (we && (wr_addr == rd2_addr)) ? wr_data : regs[rd2_addr];

endmodule

// File: rtl/operand_fetch.sv
// Operand-fetch stage and ID/EX pipeline register in front of the ALU.
// Reads two sources from the register file, selects the immediate for B,
// resolves EX/MEM hazards and registers operands and ALU controls.
// Ports: clk, rst (async, active-high), bus (operand_fetch_if.slave: decode
// handshake, WB/EX/MEM producer info, flush, execute handshake, stall_cnt).
// Build option: define FWD_EN to forward EX/MEM results instead of stalling.
module operand_fetch
    import operand_fetch_pkg::*;
#(
    parameter int unsigned DATA_W      = DATA_W_DEF,
    parameter int unsigned NREGS       = NREGS_DEF,
    parameter int unsigned STALL_CNT_W = STALL_CNT_W_DEF
) (
    input logic           clk,
    input logic           rst,
    operand_fetch_if.slave bus
);

    logic [DATA_W-1:0] rf_a;
    logic [DATA_W-1:0] rf_b;
    logic [DATA_W-1:0] opnd_a_c;
    logic [DATA_W-1:0] opnd_b_c;
    logic              ex_hit_a;
    logic              ex_hit_b;
    logic              mem_hit_a;
    logic              mem_hit_b;
    logic              hazard_c;
    logic              accept_c;

    operand_fetch_reg_file #(
        .DATA_W (DATA_W),
        .NREGS  (NREGS)
    ) u_reg_file (
        .clk      (clk),
        .rst      (rst),
        .rd1_addr (bus.src1_addr),
        .rd1_data (rf_a),
        .rd2_addr (bus.src2_addr),
        .rd2_data (rf_b),
        .we       (bus.wb_we),
        .wr_addr  (bus.wb_addr),
        .wr_data  (bus.wb_data)
    );

    // source matches against in-flight producers; src2 only matters without an immediate
    assign ex_hit_a  = bus.ex_vld  && (bus.ex_addr  == bus.src1_addr);
    assign mem_hit_a = bus.mem_vld && (bus.mem_addr == bus.src1_addr);
    assign ex_hit_b  = bus.ex_vld  && (bus.ex_addr  == bus.src2_addr) && !bus.use_imm;
    assign mem_hit_b = bus.mem_vld && (bus.mem_addr == bus.src2_addr) && !bus.use_imm;

`ifdef FWD_EN
    // operand select, priority EX > MEM > register file (which already holds the WB bypass)
    always_comb begin
        opnd_a_c = rf_a;
        if (mem_hit_a) opnd_a_c = bus.mem_data;
        if (ex_hit_a)  opnd_a_c = bus.ex_data;
        opnd_b_c = rf_b;
        if (mem_hit_b) opnd_b_c = bus.mem_data;
        if (ex_hit_b)  opnd_b_c = bus.ex_data;
        if (bus.use_imm) opnd_b_c = bus.imm;
    end
    assign hazard_c = 1'b0;
`else
    // no forwarding path: any EX/MEM match waits until the producer reaches WB
    assign opnd_a_c = rf_a;
    assign opnd_b_c = bus.use_imm ? bus.imm : rf_b;
    assign hazard_c = ex_hit_a || mem_hit_a || ex_hit_b || mem_hit_b;
    logic unused_fwd_data;
    assign unused_fwd_data = ^{bus.ex_data, bus.mem_data};
`endif

    assign bus.in_ready = !bus.flush && !hazard_c && (!bus.out_valid || bus.out_ready);
    assign accept_c     = bus.in_valid && bus.in_ready;

    // ID/EX pipeline register; flush wins, outputs hold while the consumer stalls
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.out_valid    <= 1'b0;
            bus.A            <= '0;
            bus.B            <= '0;
            bus.Op           <= '0;
            bus.passthrough  <= 1'b0;
            bus.invA         <= 1'b0;
            bus.invB         <= 1'b0;
            bus.sign         <= 1'b0;
            bus.Cin          <= 1'b0;
            bus.dst_addr_out <= '0;
            bus.dst_we_out   <= 1'b0;
        end else if (bus.flush) begin
            bus.out_valid  <= 1'b0;
            bus.dst_we_out <= 1'b0;
        end else if (accept_c) begin
            bus.out_valid    <= 1'b1;
            bus.A            <= opnd_a_c;
            bus.B            <= opnd_b_c;
            bus.Op           <= bus.op_in;
            bus.passthrough  <= bus.ctrl_in.passthrough;
            bus.invA         <= bus.ctrl_in.inv_a;
            bus.invB         <= bus.ctrl_in.inv_b;
            bus.sign         <= bus.ctrl_in.sign;
            bus.Cin          <= bus.ctrl_in.cin;
            bus.dst_addr_out <= bus.dst_addr_in;
            bus.dst_we_out   <= bus.dst_we_in;
        end else if (bus.out_valid && bus.out_ready) begin
            bus.out_valid  <= 1'b0;
            bus.dst_we_out <= 1'b0;
        end
    end

    // saturating count of cycles a presented instruction is held back by a hazard
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.stall_cnt <= '0;
        end else if (bus.in_valid && hazard_c && !bus.flush && !(&bus.stall_cnt)) begin
            bus.stall_cnt <= bus.stall_cnt + STALL_CNT_W'(1);
        end
    end

endmodule
